// File: rtl/draw_board_control_pkg.sv
// Shared constants, draw codes and FSM state encoding for the board-drawing sequencer.
// Imported by the interface, the request latch and the top-level controller.
package draw_board_control_pkg;

    localparam int N_CELLS  = 64;
    localparam int CELL_PX  = 256;
    localparam int BOARD_PX = 32768;

    localparam logic [4:0] DRAW_BOARD = 5'b11000;
    localparam logic [4:0] DRAW_TURN  = 5'b11100;
    localparam logic [4:0] DRAW_EMPTY = 5'b00000;
    localparam logic [4:0] DRAW_WALL  = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_LATCH = 3'd3,
        S_CELL  = 3'd4,
        S_NEXT  = 3'd5,
        S_TURN  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Datapath draw codes are 6 bits wide; the fixed codes live in the low five.
    function automatic logic [5:0] draw_code(input logic [4:0] code);
        return {1'b0, code};
    endfunction

endpackage

// File: rtl/draw_board_control_if.sv
// Signal bundle between game control, the draw datapath, the board RAM and the sequencer.
// master = sequencer side, slave = everything around it.
interface draw_board_control_if;
    import draw_board_control_pkg::*;

    // start is level-sampled every cycle; a request seen while busy is remembered and
    // served right after the current pass. done pulses for exactly one cycle per pass.
    logic       start;
    logic       full_redraw;
    logic       busy;
    logic       done;
    logic [5:0] board_addr;
    logic [5:0] board_rdata;
    logic       write;
    logic       update_x_y;
    logic [5:0] draw_value;
    state_t     dbg_state;

    modport master (
        input  start, full_redraw, board_rdata,
        output busy, done, board_addr, write, update_x_y, draw_value, dbg_state
    );

    modport slave (
        output start, full_redraw, board_rdata,
        input  busy, done, board_addr, write, update_x_y, draw_value, dbg_state
    );

endinterface

// File: rtl/draw_board_control_req_latch.sv
// Remembers redraw requests that arrive while a pass is running and coalesces them
// into one; a full request anywhere in the batch makes the follow-up pass a full one.
module draw_board_control_req_latch (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    input  logic full_i,
    input  logic busy_i,
    input  logic consume_i,
    output logic pending_o,
    output logic pending_full_o
);

    logic pending_q, pending_d;
    logic pending_full_q, pending_full_d;
    logic set;

    assign set = start_i & busy_i;

    // Outputs include this cycle's request so a start in the DONE cycle is not lost.
    assign pending_o      = pending_q | set;
    assign pending_full_o = pending_full_q | (set & full_i);

    always_comb begin
        pending_d      = pending_o;
        pending_full_d = pending_full_o;
        if (consume_i) begin
            pending_d      = 1'b0;
            pending_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q      <= 1'b0;
            pending_full_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: rtl/draw_board_control.sv
// Board-drawing sequencer: optional white clear, 64 RAM-fetched cells, then the turn
// indicator, emitted as write/update_x_y/draw_value for the draw datapath.
module draw_board_control
    import draw_board_control_pkg::*;
#(
    parameter int N_CELLS_P  = N_CELLS,
    parameter int CELL_PX_P  = CELL_PX,
    parameter int BOARD_PX_P = BOARD_PX
) (
    input  logic                  clk,
    input  logic                  resetn,
    draw_board_control_if.master  bus
);

    localparam logic [14:0] BOARD_LAST = 15'(BOARD_PX_P - 1);
    localparam logic [14:0] CELL_LAST  = 15'(CELL_PX_P - 1);
    localparam logic [5:0]  CELL_MAX   = 6'(N_CELLS_P - 1);

    state_t      state_q, state_d;
    logic [5:0]  cell_q, cell_d;
    logic [14:0] pix_q, pix_d;
    logic [5:0]  val_q, val_d;
    logic        consume;
    logic        pending;
    logic        pending_full;
    logic        write_c;
    logic        update_c;
    logic [5:0]  draw_c;

    draw_board_control_req_latch u_req_latch (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (bus.start),
        .full_i         (bus.full_redraw),
        .busy_i         (state_q != S_IDLE),
        .consume_i      (consume),
        .pending_o      (pending),
        .pending_full_o (pending_full)
    );

    // The pixel counter defaults to zero so it reloads on every state entry.
    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        pix_d    = '0;
        val_d    = val_q;
        consume  = 1'b0;
        write_c  = 1'b0;
        update_c = 1'b0;
        draw_c   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = bus.full_redraw ? S_CLEAR : S_FETCH;
                    cell_d  = '0;
                end
            end
            S_CLEAR: begin
                write_c = 1'b1;
                draw_c  = draw_code(DRAW_BOARD);
                if (pix_q == BOARD_LAST) begin
                    state_d = S_FETCH;
                    cell_d  = '0;
                end else begin
                    pix_d = pix_q + 15'd1;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // RAM data for the address shown in FETCH is valid now.
                val_d   = bus.board_rdata;
                state_d = S_CELL;
            end
            S_CELL: begin
                write_c = 1'b1;
                draw_c  = val_q;
                if (pix_q == CELL_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    pix_d = pix_q + 15'd1;
                end
            end
            S_NEXT: begin
                update_c = 1'b1;
                if (cell_q == CELL_MAX) begin
                    cell_d  = '0;
                    state_d = S_TURN;
                end else begin
                    cell_d  = cell_q + 6'd1;
                    state_d = S_FETCH;
                end
            end
            S_TURN: begin
                write_c = 1'b1;
                draw_c  = draw_code(DRAW_TURN);
                if (pix_q == CELL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    pix_d = pix_q + 15'd1;
                end
            end
            S_DONE: begin
                consume = 1'b1;
                if (pending) begin
                    state_d = pending_full ? S_CLEAR : S_FETCH;
                    cell_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cell_q  <= '0;
            pix_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            pix_q   <= pix_d;
            val_q   <= val_d;
        end
    end

    // All outputs derive from registered state, so reset clears them asynchronously.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.board_addr = cell_q;
    assign bus.write      = write_c;
    assign bus.update_x_y = update_c;
    assign bus.draw_value = draw_c;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_draw_board_control.sv
// Randomized bench for draw_board_control: a pass-level reference model predicts the
// draw stream, pass length and pulse counts of each redraw pass.
module tb_draw_board_control;
    import draw_board_control_pkg::*;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    draw_board_control_if bus ();

    draw_board_control dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] ram [N_CELLS];
    bit         toggle;
    bit         exp_pass_q[$];

    // Board RAM: registered read, optionally scrambled while the datapath is writing.
    always @(posedge clk) begin
        bus.board_rdata <= (toggle && bus.write) ? 6'($urandom_range(0, 63)) : ram[bus.board_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a pass is a flat list of write values, described arithmetically.
    function automatic logic [5:0] exp_write_val(input bit full, input int idx);
        int k;
        k = idx;
        if (full) begin
            if (k < BOARD_PX) return 6'b011000;
            k = k - BOARD_PX;
        end
        if (k < N_CELLS * CELL_PX) return ram[k / CELL_PX];
        return 6'b011100;
    endfunction

    function automatic int exp_len(input bit full);
        return (full ? BOARD_PX : 0) + N_CELLS * (CELL_PX + 3) + CELL_PX + 1;
    endfunction

    function automatic int exp_writes(input bit full);
        return (full ? BOARD_PX : 0) + N_CELLS * CELL_PX + CELL_PX;
    endfunction

    bit cur_full;
    bit in_pass;
    int cyc, wcnt, ucnt, verr, perr;
    int busy_run, last_run, done_cnt;

    always @(negedge clk) begin
        if (!resetn) begin
            in_pass  = 1'b0;
            busy_run = 0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_run = busy_run;
                busy_run = 0;
            end
            if (bus.busy && !in_pass) begin
                chk("pass_expected", 32'(exp_pass_q.size() != 0), 1);
                cur_full = (exp_pass_q.size() != 0) ? exp_pass_q.pop_front() : 1'b0;
                in_pass  = 1'b1;
                cyc      = 0;
                wcnt     = 0;
                ucnt     = 0;
                verr     = 0;
                perr     = 0;
                if (!cur_full) chk("first_addr", 32'(bus.board_addr), 0);
            end
            if (in_pass) begin
                if (bus.write) begin
                    if (bus.draw_value !== exp_write_val(cur_full, wcnt)) verr++;
                    wcnt++;
                end
                if (bus.update_x_y) ucnt++;
                if (bus.write && bus.update_x_y) perr++;
                if (bus.done && bus.write) perr++;
                if (bus.done) begin
                    chk("pass_len", cyc + 1, exp_len(cur_full));
                    chk("write_count", wcnt, exp_writes(cur_full));
                    chk("update_count", ucnt, N_CELLS);
                    chk("draw_value_errors", verr, 0);
                    chk("protocol_errors", perr, 0);
                    in_pass = 1'b0;
                    done_cnt++;
                end else begin
                    cyc++;
                end
            end
        end
    end

    task automatic pulse_start(input bit full);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.full_redraw = full;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.full_redraw = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_write"}, 32'(bus.write), 0);
        chk({tag, "_upd"},   32'(bus.update_x_y), 0);
        chk({tag, "_draw"},  32'(bus.draw_value), 0);
        chk({tag, "_addr"},  32'(bus.board_addr), 0);
        chk({tag, "_state"}, 32'(bus.dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int gaps [3];
        int full_idx;
        int done_base;
        checks          = 0;
        failures        = 0;
        done_cnt        = 0;
        last_run        = 0;
        toggle          = 1'b0;
        resetn          = 1'b0;
        bus.start       = 1'b0;
        bus.full_redraw = 1'b0;
        for (int i = 0; i < N_CELLS; i++) ram[i] = 6'(i);

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;

        // start coinciding with reset in IDLE must be ignored
        @(posedge clk);
        #1;
        resetn    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_start_busy", 32'(bus.busy), 0);

        // partial pass cut by an asynchronous reset at cell 10, pixel 100
        exp_pass_q.push_back(1'b0);
        pulse_start(1'b0);
        repeat (10 * (CELL_PX + 3) + 2 + 100) @(posedge clk);
        #1;
        chk("pre_reset_write", 32'(bus.write), 1);
        chk("pre_reset_draw", 32'(bus.draw_value), 10);
        #1;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // partial pass with three coalesced requests, one of them full
        toggle = 1'b1;
        exp_pass_q.push_back(1'b0);
        exp_pass_q.push_back(1'b1);
        done_base = done_cnt;
        pulse_start(1'b0);
        full_idx = $urandom_range(0, 2);
        for (int i = 0; i < 3; i++) gaps[i] = $urandom_range(10, 5000);
        for (int i = 0; i < 3; i++) begin
            repeat (gaps[i]) @(posedge clk);
            pulse_start(i == full_idx);
        end
        wait_idle(exp_len(1'b0) + exp_len(1'b1) + 100);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - done_base, 2);
        chk("busy_run", last_run, exp_len(1'b0) + exp_len(1'b1));
        chk("passes_left", exp_pass_q.size(), 0);
        chk("pass_open", 32'(in_pass), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/draw_board_control.md
Name: draw_board_control

Overview:
- Initiator-side sequencer for the board-drawing datapath.
- Issues the `write`/`update_x_y`/`draw_value` command stream the datapath consumes, in this order:
  - optional full white board clear,
  - all 64 cells, each fetched from the board RAM,
  - player-turn indicator.
- Sits between game control (start/done handshake) and the draw datapath plus board RAM read port.

Parameters:
- N_CELLS, 64, cells per pass; also the `x_y_pos` wrap modulus.
- CELL_PX, 256, write cycles per cell and for the turn indicator (16x16).
- BOARD_PX, 32768, write cycles for the board clear (15-bit sweep).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  redraw request, sampled every cycle
- full_redraw  in  1  qualifies start: 1 = include board clear
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at pass end
- board_addr  out  6  board RAM read address, {y,x}
- board_rdata  in  6  board RAM data, valid 1 cycle after board_addr
- write  out  1  datapath write strobe
- update_x_y  out  1  datapath cell-advance pulse
- draw_value  out  6  datapath draw code

Behaviour:
- Reset (async on resetn low, any state) drives these values:
  - state=IDLE; busy, done, write, update_x_y = 0
  - draw_value = 0, board_addr = 0
  - cell index, pixel counter, pending flags = 0
- resetn also clears the datapath's counter, long_counter and x_y_pos, which keeps both sides aligned after a mid-pass reset.
- States: IDLE, CLEAR, FETCH, LATCH, CELL, NEXT, TURN, DONE.
- IDLE:
  - start=1 -> CLEAR if full_redraw=1, else FETCH.
  - busy rises in the following cycle.
- CLEAR:
  - write=1, draw_value=6'b011000, for exactly BOARD_PX consecutive cycles.
  - Then -> FETCH with cell=0.
- FETCH:
  - board_addr=cell, write=0.
  - One cycle, -> LATCH.
- LATCH:
  - Capture board_rdata into a value register; write=0.
  - -> CELL.
- CELL:
  - write=1, draw_value=latched value, for exactly CELL_PX cycles.
  - board_rdata changes during CELL have no effect.
  - -> NEXT.
- NEXT:
  - update_x_y=1 for one cycle, write=0, cell increments.
  - cell was N_CELLS-1 -> wrap to 0 and go to TURN; else -> FETCH.
- TURN:
  - write=1, draw_value=6'b011100, for CELL_PX cycles.
  - -> DONE.
- DONE:
  - done=1 for one cycle; busy drops next cycle unless a pending request exists.
- write and update_x_y are never high in the same cycle. write is never high in IDLE, FETCH, LATCH, NEXT or DONE.
- Pixel counter width is 15 bits, shared by CLEAR, CELL and TURN. It reloads to 0 on every state entry.
- Pass lengths, from the first active state through the DONE cycle inclusive:
  - full pass: 32768 + 64*259 + 256 + 1 = 49601 cycles
  - partial pass: 16833 cycles
- Exactly 64 update_x_y pulses per pass, so the datapath's x_y_pos returns to 0.
- start while busy:
  - Sets pending=1; pending_full |= full_redraw.
  - Multiple requests coalesce into one.
- DONE with pending=1:
  - done still pulses.
  - Next state is CLEAR (pending_full=1) or FETCH; busy stays high; pending flags clear.
- start in the DONE cycle itself counts as pending.
- start in IDLE together with a same-cycle reset: reset wins.

Decomposition:
- Shared package holds:
  - draw codes: DRAW_BOARD=5'b11000, DRAW_TURN=5'b11100, DRAW_EMPTY=5'b00000, DRAW_WALL=5'b11111
  - state encoding
  - N_CELLS / CELL_PX / BOARD_PX defaults
- Optional sub-module draw_req_latch: pending/pending_full coalescing with clear-on-consume.
- The FSM and counters stay in one module.

Test Plan:
- Reset mid-CELL (resetn low at cell 10, pixel 100) -> all outputs 0 and IDLE immediately, asynchronously; after release, a partial start gives a 16833-cycle pass beginning at board_addr=0.
- Partial redraw, RAM preloaded with addr[5:0] as data:
  - board_addr sequence is 0..63;
  - per cell, draw_value equals the address for exactly 256 write cycles;
  - 64 update_x_y pulses;
  - then 256 cycles of 6'b011100;
  - done at cycle 16833.
- Full redraw:
  - first 32768 write cycles carry draw_value 6'b011000, contiguous;
  - done at cycle 49601;
  - busy high throughout.
- board_rdata toggled randomly during CELL -> draw_value holds the value latched in LATCH for all 256 cycles.
- Three start pulses during a partial pass, one with full_redraw=1:
  - exactly one extra pass follows, and it starts with CLEAR;
  - done pulses twice;
  - busy never drops between the passes.
- Protocol checker over a full pass:
  - write and update_x_y never overlap;
  - write count per pass = 32768 + 64*256 + 256 = 49408.
